// File: rtl/oflow_score_feeder_if.sv
// rtl/oflow_score_feeder_if.sv - feature stream, score-calc bus and result stream bundle
interface oflow_score_feeder_if #(
  parameter int DATA_W = 112,
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic [DATA_W-1:0] sc_data_in;
  logic              sc_wr;
  logic [ADDR_W-1:0] sc_addr;
  logic              sc_en;
  logic [DATA_W-1:0] sc_data_out;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_last;
  logic              res_ready;
  logic              busy;
  logic              err;

  modport master (
    input  in_valid, in_data, in_last, sc_data_out, res_ready,
    output in_ready, sc_data_in, sc_wr, sc_addr, sc_en,
    output res_valid, res_data, res_last, busy, err
  );

  modport slave (
    output in_valid, in_data, in_last, sc_data_out, res_ready,
    input  in_ready, sc_data_in, sc_wr, sc_addr, sc_en,
    input  res_valid, res_data, res_last, busy, err
  );
endinterface

// File: rtl/oflow_score_feeder.sv
// rtl/oflow_score_feeder.sv - loads a feature frame into score-calc, runs it, streams results back
// Optional overflow guard: OFLOW_FEEDER_OVF_CHECK_EN
module oflow_score_feeder #(
  parameter int              DATA_W      = 112,
  parameter int              ADDR_W      = 8,
  parameter int              MAX_WORDS   = 16,
  parameter int              CALC_CYCLES = 4,
  parameter logic [ADDR_W-1:0] RES_ADDR  = 8'hF0,
  parameter int              RES_WORDS   = 2
) (
  input  logic                  clk,
  input  logic                  reset_N,
  oflow_score_feeder_if.master  bus
);
  localparam int WPTR_W = $clog2(MAX_WORDS) + 1;
  localparam int CNT_W  = $clog2(CALC_CYCLES + 1) + 1;
  localparam int RPTR_W = $clog2(RES_WORDS) + 1;

  typedef enum logic [1:0] {LOAD, CALC, READ} state_t;
  state_t state, state_nx;

  logic [WPTR_W-1:0] wptr;
  logic [CNT_W-1:0]  calc_cnt;
  logic [RPTR_W-1:0] rptr;
  logic [1:0]        rd_stage;
  logic              accept, res_done, calc_done;
  logic [ADDR_W-1:0] res_addr_nx;

  assign bus.in_ready = (state == LOAD);
  assign bus.busy     = (state != LOAD);
  assign accept       = bus.in_valid && (state == LOAD);
  assign res_done     = bus.res_valid && bus.res_ready;
  assign calc_done    = (calc_cnt == CNT_W'(CALC_CYCLES));
  assign res_addr_nx  = RES_ADDR + ADDR_W'(rptr) + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_N) state <= LOAD;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (accept && bus.in_last) state_nx = CALC;
      CALC:    if (calc_done) state_nx = READ;
      READ:    if (res_done && bus.res_last) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_N) begin
      wptr           <= '0;
      calc_cnt       <= '0;
      rptr           <= '0;
      rd_stage       <= 2'd0;
      bus.sc_data_in <= '0;
      bus.sc_wr      <= 1'b0;
      bus.sc_addr    <= '0;
      bus.sc_en      <= 1'b0;
      bus.res_valid  <= 1'b0;
      bus.res_data   <= '0;
      bus.res_last   <= 1'b0;
    end else begin
      bus.sc_wr <= 1'b0;
      bus.sc_en <= 1'b0;
      case (state)
        LOAD: begin
          calc_cnt <= '0;
          rptr     <= '0;
          rd_stage <= 2'd0;
          if (accept) begin
`ifdef OFLOW_FEEDER_OVF_CHECK_EN
            // Words past the last address are swallowed so the frame can still close.
            if (wptr != WPTR_W'(MAX_WORDS)) begin
              bus.sc_wr      <= 1'b1;
              bus.sc_addr    <= ADDR_W'(wptr);
              bus.sc_data_in <= DATA_W'(bus.in_data);
              wptr           <= wptr + 1'b1;
            end
`else
            bus.sc_wr      <= 1'b1;
            bus.sc_addr    <= ADDR_W'(wptr);
            bus.sc_data_in <= DATA_W'(bus.in_data);
            wptr           <= (wptr == WPTR_W'(MAX_WORDS - 1)) ? '0 : wptr + 1'b1;
`endif
          end
        end
        CALC: begin
          // First CALC cycle carries the final write; the enable window follows it.
          calc_cnt  <= calc_cnt + 1'b1;
          bus.sc_en <= (calc_cnt < CNT_W'(CALC_CYCLES));
          if (calc_done) begin
            bus.sc_addr <= RES_ADDR;
            rd_stage    <= 2'd1;
          end
        end
        READ: begin
          // stage 1: address on the bus, stage 2: score-calc data valid, 0: holding result
          case (rd_stage)
            2'd1: rd_stage <= 2'd2;
            2'd2: begin
              bus.res_data  <= DATA_W'(bus.sc_data_out);
              bus.res_valid <= 1'b1;
              bus.res_last  <= (rptr == RPTR_W'(RES_WORDS - 1));
              rd_stage      <= 2'd0;
            end
            default: begin
              if (res_done) begin
                bus.res_valid <= 1'b0;
                bus.res_last  <= 1'b0;
                if (bus.res_last) begin
                  wptr <= '0;
                end else begin
                  rptr        <= rptr + 1'b1;
                  bus.sc_addr <= res_addr_nx;
                  rd_stage    <= 2'd1;
                end
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef OFLOW_FEEDER_OVF_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset_N)                                           bus.err <= 1'b0;
    else if (accept && (wptr == WPTR_W'(MAX_WORDS)))        bus.err <= 1'b1;
  end
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_oflow_score_feeder.sv
// tb/tb_oflow_score_feeder.sv - randomized frames against a frame-level reference model
module tb_oflow_score_feeder;
  localparam int          MAXW      = 16;
  localparam int          CALC      = 4;
  localparam logic [7:0]  RES_ADDR  = 8'hF0;
  localparam int          RES_WORDS = 2;
`ifdef OFLOW_FEEDER_OVF_CHECK_EN
  localparam bit OVF_MODE = 1'b1;
`else
  localparam bit OVF_MODE = 1'b0;
`endif

  typedef struct {
    logic [7:0]   a;
    logic [111:0] d;
    int           c;
  } wr_t;

  logic clk = 1'b0;
  logic reset_N = 1'b0;
  oflow_score_feeder_if #(.DATA_W(112), .ADDR_W(8)) bus ();

  oflow_score_feeder dut (
    .clk     (clk),
    .reset_N (reset_N),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  logic [111:0] rmem [256];
  wr_t wr_q[$];
  int en_first, en_last, en_cnt, overlap;
  bit err_exp = 1'b0;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [111:0] rnd112();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[111:0];
  endfunction

  // One clock; models the registered score-calc read port and logs bus activity.
  task automatic tick();
    logic [7:0] a;
    a = bus.sc_addr;
    @(posedge clk);
    #1;
    cyc++;
    bus.sc_data_out = rmem[a];
    if (bus.sc_wr) wr_q.push_back('{a: bus.sc_addr, d: bus.sc_data_in, c: cyc});
    if (bus.sc_en) begin
      if (en_cnt == 0) en_first = cyc;
      en_last = cyc;
      en_cnt++;
      if (bus.sc_wr) overlap++;
    end
  endtask

  task automatic do_reset();
    reset_N = 1'b0;
    tick();
    reset_N = 1'b1;
    err_exp = 1'b0;
  endtask

  task automatic feed(int n, output logic [111:0] words[$], output int acc_c[$]);
    int acc, budget;
    bit take;
    words.delete();
    acc_c.delete();
    for (int i = 0; i < n; i++) words.push_back(rnd112());
    acc = 0;
    budget = 0;
    while (acc < n && budget < 400) begin
      bus.in_valid = ($urandom_range(3) != 0);
      bus.in_data  = words[acc];
      bus.in_last  = (acc == n - 1);
      take = bus.in_valid && bus.in_ready;
      if (take) acc_c.push_back(cyc);
      tick();
      if (take) acc++;
      budget++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("load_accepted", acc, n);
  endtask

  task automatic run_frame(int n, bit hold5);
    logic [111:0] words[$];
    logic [111:0] exp_res[$];
    logic [111:0] held;
    int acc_c[$];
    int got, budget, nw;
    logic [7:0] ra;
    for (int i = 0; i < RES_WORDS; i++) begin
      ra = RES_ADDR + 8'(i);
      rmem[ra] = rnd112();
      exp_res.push_back(rmem[ra]);
    end
    wr_q.delete();
    en_cnt = 0;
    overlap = 0;
    feed(n, words, acc_c);

    got = 0;
    budget = 0;
    while (got < RES_WORDS && budget < 400) begin
      if (hold5 && got == 0 && bus.res_valid) begin
        held = bus.res_data;
        bus.res_ready = 1'b0;
        repeat (5) begin
          tick();
          check("hold_valid", bus.res_valid, 1);
          check("hold_data", bus.res_data, held);
          check("hold_addr", bus.sc_addr, RES_ADDR);
        end
        hold5 = 1'b0;
      end
      bus.res_ready = ($urandom_range(1) == 1);
      check("busy_in_frame", bus.busy, 1);
      check("in_ready_in_frame", bus.in_ready, 0);
      if (bus.res_valid && bus.res_ready) begin
        check("res_data", bus.res_data, exp_res[got]);
        check("res_last", bus.res_last, (got == RES_WORDS - 1));
        got++;
      end
      tick();
      budget++;
    end
    bus.res_ready = 1'b0;
    check("res_count", got, RES_WORDS);
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_busy", bus.busy, 0);

    nw = (OVF_MODE && n > MAXW) ? MAXW : n;
    if (OVF_MODE && n > MAXW) err_exp = 1'b1;
    check("wr_count", wr_q.size(), nw);
    for (int i = 0; i < wr_q.size() && i < nw; i++) begin
      check("wr_addr", wr_q[i].a, 8'(i % MAXW));
      check("wr_data", wr_q[i].d, words[i]);
      check("wr_latency", wr_q[i].c, acc_c[i] + 1);
    end
    check("en_cycles", en_cnt, CALC);
    check("en_contiguous", en_last - en_first + 1, CALC);
    check("en_wr_overlap", overlap, 0);
    if (!(OVF_MODE && n > MAXW) && wr_q.size() > 0)
      check("en_start", en_first, wr_q[wr_q.size() - 1].c + 1);
    check("err", bus.err, err_exp);
  endtask

  task automatic abort_in_calc(int n);
    logic [111:0] words[$];
    int acc_c[$];
    int budget;
    en_cnt = 0;
    feed(n, words, acc_c);
    budget = 0;
    while (en_cnt < 2 && budget < 50) begin
      tick();
      budget++;
    end
    check("abort_reached_calc2", en_cnt, 2);
    do_reset();
    check("abort_sc_en", bus.sc_en, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_res_valid", bus.res_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_err", bus.err, 0);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_last     = 1'b0;
    bus.res_ready   = 1'b0;
    bus.sc_data_out = '0;
    en_first = 0;
    en_last  = 0;
    en_cnt   = 0;
    overlap  = 0;
    tick();
    do_reset();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_sc_wr", bus.sc_wr, 0);
    check("rst_sc_en", bus.sc_en, 0);
    check("rst_sc_addr", bus.sc_addr, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_last", bus.res_last, 0);
    check("rst_err", bus.err, 0);

    run_frame(3, 1'b1);
    run_frame(1, 1'b0);
    run_frame(18, 1'b0);
    repeat (6) run_frame($urandom_range(20, 1), 1'b0);
    abort_in_calc(5);
    run_frame(3, 1'b0);
    run_frame(MAXW, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
